// File: rtl/bank_stream_reader_pkg.sv
// Shared definitions for the coefficient bank read/write controllers:
// bank geometry and the controller state encoding.
package bank_stream_reader_pkg;

    localparam int BANK_AW    = 7;
    localparam int BANK_DW    = 14;
    localparam int BANK_DEPTH = 1 << BANK_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } bank_state_e;

endpackage

// File: rtl/bank_stream_reader_sync_fifo.sv
// Small synchronous FIFO used as the output buffer of the bank stream reader.
// Push and pop may coincide at any occupancy, including full-with-pop.
module bank_stream_reader_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 14,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 2) ? 2 : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_eff;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign pop_eff = pop_i & valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop_eff) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        count_d = count_q + CW'(push_i) - CW'(pop_eff);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/bank_stream_reader.sv
// Streams a contiguous, wrapping address range out of a coefficient bank as a
// valid/ready beat stream, buffering the bank read latency in a credit-limited FIFO.
module bank_stream_reader
    import bank_stream_reader_pkg::*;
#(
    parameter int AW         = BANK_AW,
    parameter int DW         = BANK_DW,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          bank_en,
    output logic          bank_ren,
    output logic [AW-1:0] bank_raddr,
    input  logic [DW-1:0] bank_q,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    bank_state_e   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   issue_rem_q, issue_rem_d;
    logic [AW:0]   beat_rem_q, beat_rem_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;

    logic          issue;
    logic          pop;
    logic          fifo_valid;
    logic [DW-1:0] fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [3:0]    occ_after_pop;

    // A zero length encodes a full sweep of the bank.
    function automatic logic [AW:0] norm_len(input logic [AW:0] l);
        return (l == '0) ? {1'b1, {AW{1'b0}}} : l;
    endfunction

    assign pop           = fifo_valid & m_ready;
    assign occ_after_pop = 4'(fifo_count) + 4'(inflight_q) - 4'(pop);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        beat_rem_d  = beat_rem_q;
        done_d      = 1'b0;
        issue       = 1'b0;

        if (pop) begin
            beat_rem_d = beat_rem_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    issue_rem_d = norm_len(len);
                    beat_rem_d  = norm_len(len);
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((issue_rem_q != '0) && (occ_after_pop < 4'(FIFO_DEPTH))) begin
                    issue       = 1'b1;
                    addr_d      = addr_q + 1'b1;
                    issue_rem_d = issue_rem_q - 1'b1;
                end
                if (issue_rem_d == '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave on the cycle the last beat is accepted so done and busy=0 land together.
                if (beat_rem_d == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign inflight_d = issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            issue_rem_q <= '0;
            beat_rem_q  <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            beat_rem_q  <= beat_rem_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
        end
    end

    // Bank data returns one cycle after issue and is captured into the FIFO.
    bank_stream_reader_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_sync_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (inflight_q),
        .wdata_i (bank_q),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign bank_en    = issue;
    assign bank_ren   = issue;
    assign bank_raddr = addr_q;
    assign m_valid    = fifo_valid;
    assign m_data     = fifo_rdata;
    assign m_last     = fifo_valid && (beat_rem_q == {{AW{1'b0}}, 1'b1});

endmodule

// File: tb/tb_bank_stream_reader.sv
// Randomized self-checking bench for bank_stream_reader against a queue-based
// model of the expected address/data stream.
module tb_bank_stream_reader;

    localparam int AW    = 7;
    localparam int LW    = AW + 1;
    localparam int DW    = 14;
    localparam int FD    = 2;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, bank_en, bank_ren, m_valid, m_last;
    logic [AW-1:0] bank_raddr;
    logic [DW-1:0] bank_q = '0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DW-1:0] mem [DEPTH];
    int exp_data_q[$];
    int exp_addr_q[$];

    bit            mon_en = 1'b0;
    bit            done_seen = 1'b0;
    bit            hold_q = 1'b0;
    logic [DW-1:0] hold_data = '0;
    int issued, popped, start_cyc, first_issue_cyc, first_valid_cyc;
    int first_pop_cyc, last_pop_cyc, done_due;

    bank_stream_reader #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .bank_en    (bank_en),
        .bank_ren   (bank_ren),
        .bank_raddr (bank_raddr),
        .bank_q     (bank_q),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: registered read, junk on the data bus when no read was issued.
    always @(posedge clk) bank_q <= bank_en ? mem[bank_raddr] : DW'($urandom);

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Stream monitor: compares issues and accepted beats against the model queues.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bank_ren !== bank_en) chk("ren_eq_en", int'(bank_ren), int'(bank_en));
            if (bank_en) begin
                if (first_issue_cyc < 0) begin
                    first_issue_cyc = cyc;
                    chk("issue_latency", first_issue_cyc - start_cyc, 1);
                end
                if (exp_addr_q.size() == 0) chk("extra_issue", 1, 0);
                else chk("raddr", int'(bank_raddr), exp_addr_q.pop_front());
                issued++;
            end
            if (m_valid && first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                chk("fill_latency", first_valid_cyc - first_issue_cyc, 2);
            end
            if (hold_q) begin
                chk("hold_valid", int'(m_valid), 1);
                chk("hold_data", int'(m_data), int'(hold_data));
            end
            hold_q    = m_valid && !m_ready;
            hold_data = m_data;
            if (m_valid && m_ready) begin
                popped++;
                if (exp_data_q.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    chk("m_data", int'(m_data), exp_data_q.pop_front());
                    chk("m_last", int'(m_last), int'(exp_data_q.size() == 0));
                    if (exp_data_q.size() == 0) done_due = cyc + 1;
                end
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
            if (bank_en || (m_valid && m_ready)) chk("occupancy", int'((issued - popped) <= FD), 1);
            if (done || cyc == done_due) begin
                chk("done", int'(done), int'(cyc == done_due));
                if (cyc == done_due) chk("busy_at_done", int'(busy), 0);
            end
            if (done) done_seen = 1'b1;
        end
    end

    // mode 0: m_ready held high; 1: ready pattern 1,0,0; 2: random ready.
    task automatic run_cmd(input int base, input int lv, input int mode, input bit poke);
        int n;
        n = (lv == 0) ? DEPTH : lv;
        exp_data_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back((base + i) % DEPTH);
            exp_data_q.push_back(int'(mem[(base + i) % DEPTH]));
        end
        issued = 0; popped = 0; done_due = -1; done_seen = 1'b0; hold_q = 1'b0;
        first_issue_cyc = -1; first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
        m_ready = (mode != 2);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); len = LW'(lv); start_cyc = cyc; mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 1500 && !done_seen; k++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (k % 3 == 2);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke && k == 3) begin
                start = 1'b1; base_addr = AW'(base + 40); len = LW'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("timeout", int'(done_seen), 1);
        chk("beats_left", exp_data_q.size(), 0);
        chk("issues_left", exp_addr_q.size(), 0);
        if (mode == 0) chk("throughput", last_pop_cyc - first_pop_cyc, n - 1);
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bank_en", int'(bank_en), 0);
        chk("rst_bank_ren", int'(bank_ren), 0);
        chk("rst_raddr", int'(bank_raddr), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_m_data", int'(m_data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_cmd(0, 4, 0, 1'b0);
        run_cmd(126, 4, 0, 1'b0);
        run_cmd(30, 8, 1, 1'b0);
        run_cmd(5, 128, 0, 1'b0);
        run_cmd(60, 10, 0, 1'b1);
        run_cmd(90, 0, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            run_cmd(int'($urandom_range(0, DEPTH - 1)),
                    (t == 5) ? int'($urandom_range(100, 128)) : int'($urandom_range(1, 20)),
                    1 + (t % 2), 1'b0);
        end

        // Reset while draining a full buffer under back-pressure.
        mon_en = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(10); len = LW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_valid", int'(m_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_valid", int'(m_valid), 0);
        chk("async_rst_bank_en", int'(bank_en), 0);
        chk("async_rst_done", int'(done), 0);
        @(negedge clk) rst_n = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_valid", int'(m_valid), 0);
        end

        // Reset in the cycle of an issued read; the returning word must not appear.
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(40); len = LW'(20);
        @(posedge clk); #1;
        start = 1'b0;
        chk("mid_run_issue", int'(bank_en), 1);
        #3 rst_n = 1'b0;
        #1 chk("mid_run_rst_bank_en", int'(bank_en), 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stale_data_valid", int'(m_valid), 0);
            chk("stale_busy", int'(busy), 0);
        end

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
        run_cmd(20, 5, 0, 1'b0);
        run_cmd(120, 16, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
